// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state and grant encodings.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    FACC  = 3'd2,
    DRESP = 3'd3,
    FRESP = 3'd4
  } state_e;

  typedef enum logic {
    GNT_DM = 1'b0,
    GNT_IF = 1'b1
  } gnt_e;

  localparam int unsigned MEM_LAT_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between fetch and data
// requesters; data has priority with a one-access anti-starvation override.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_re,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rdy,
  output logic [DATA_W-1:0] if_data,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rdy,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned    CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              starve_q, starve_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rdy_q, if_rdy_d;
  logic              dm_rdy_q, dm_rdy_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dmreq;
  logic              gnt_v;
  gnt_e              gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdy_q    <= 1'b0;
      dm_rdy_q    <= 1'b0;
      if_data_q   <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdy_q    <= if_rdy_d;
      dm_rdy_q    <= dm_rdy_d;
      if_data_q   <= if_data_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdy_d    = 1'b0;
    dm_rdy_d    = 1'b0;
    if_data_d   = if_data_q;
    dm_rdata_d  = dm_rdata_q;
    dmreq       = dm_re | dm_we;
    gnt_v       = 1'b0;
    gnt         = GNT_DM;

    unique case (state_q)
      IDLE: begin
        if (dmreq && !(if_re && starve_q)) begin
          gnt_v = 1'b1;
          gnt   = GNT_DM;
        end else if (if_re) begin
          gnt_v = 1'b1;
          gnt   = GNT_IF;
        end
        if (gnt_v) begin
          mem_en_d    = 1'b1;
          mem_wdata_d = dm_wdata;
          cnt_d       = CNT_LOAD;
          if (gnt == GNT_DM) begin
            state_d    = DACC;
            mem_addr_d = dm_addr;
            mem_we_d   = dm_we;
            starve_d   = if_re;
          end else begin
            state_d    = FACC;
            mem_addr_d = if_addr;
            mem_we_d   = 1'b0;
            starve_d   = 1'b0;
          end
        end
      end
      DACC, FACC: begin
        if (cnt_q == '0) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          // mem_we_q still reflects the access here, so writes leave dm_rdata alone
          if (state_q == DACC) begin
            dm_rdy_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
            state_d = DRESP;
          end else begin
            if_rdy_d  = 1'b1;
            if_data_d = mem_rdata;
            state_d   = FRESP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DRESP, FRESP: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  assign if_rdy    = if_rdy_q;
  assign if_data   = if_data_q;
  assign dm_rdy    = dm_rdy_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=4 and MEM_LAT=1) checked each cycle
// against a transaction-scheduling reference model, plus directed scenario checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_re = 1'b0, dm_re = 1'b0, dm_we = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;

  logic        o_ifrdy [2];
  logic        o_dmrdy [2];
  logic        o_en    [2];
  logic        o_we    [2];
  logic        o_busy  [2];
  logic [15:0] o_ifdata [2];
  logic [15:0] o_dmdata [2];
  logic [15:0] o_addr   [2];
  logic [15:0] o_wdata  [2];

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(4), .ADDR_W(16), .DATA_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .if_re(if_re), .if_addr(if_addr), .if_rdy(o_ifrdy[0]),
    .if_data(o_ifdata[0]), .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdy(o_dmrdy[0]), .dm_rdata(o_dmdata[0]), .mem_en(o_en[0]),
    .mem_we(o_we[0]), .mem_addr(o_addr[0]), .mem_wdata(o_wdata[0]), .mem_rdata(mem_rdata),
    .busy(o_busy[0]));

  mem_arbiter #(.MEM_LAT(1), .ADDR_W(16), .DATA_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .if_re(if_re), .if_addr(if_addr), .if_rdy(o_ifrdy[1]),
    .if_data(o_ifdata[1]), .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdy(o_dmrdy[1]), .dm_rdata(o_dmdata[1]), .mem_en(o_en[1]),
    .mem_we(o_we[1]), .mem_addr(o_addr[1]), .mem_wdata(o_wdata[1]), .mem_rdata(mem_rdata),
    .busy(o_busy[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: each access is a scheduled window rather than an FSM.
  // Granted in cycle g -> mem_en in g+1..g+L, rdy in g+L+1, next grant possible at g+L+2.
  int          LAT [2] = '{4, 1};
  int          g [2];
  int          free_at [2];
  bit          st [2];
  bit          adm [2];
  bit          awe [2];
  logic [15:0] aaddr [2];
  logic [15:0] awd [2];
  logic [15:0] xif [2];
  logic [15:0] xdm [2];
  byte         gl[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      g[i] = -100; free_at[i] = cyc; st[i] = 0; adm[i] = 0; awe[i] = 0;
      aaddr[i] = '0; awd[i] = '0; xif[i] = '0; xdm[i] = '0;
    end
  endtask

  task automatic model_decide(input int i);
    if (cyc >= free_at[i]) begin
      if ((dm_re || dm_we) && !(if_re && st[i])) begin
        g[i] = cyc; adm[i] = 1; awe[i] = dm_we; aaddr[i] = dm_addr; st[i] = if_re;
        awd[i] = dm_wdata; free_at[i] = cyc + LAT[i] + 2;
        if (i == 0) gl.push_back("D");
      end else if (if_re) begin
        g[i] = cyc; adm[i] = 0; awe[i] = 0; aaddr[i] = if_addr; st[i] = 0;
        awd[i] = dm_wdata; free_at[i] = cyc + LAT[i] + 2;
        if (i == 0) gl.push_back("F");
      end
    end
    if (cyc == g[i] + LAT[i]) begin
      if (!adm[i]) xif[i] = mem_rdata;
      else if (!awe[i]) xdm[i] = mem_rdata;
    end
  endtask

  task automatic model_check(input int i);
    bit en, rdy, bz;
    en  = (cyc > g[i]) && (cyc <= g[i] + LAT[i]);
    rdy = (cyc == g[i] + LAT[i] + 1);
    bz  = (cyc > g[i]) && (cyc <= g[i] + LAT[i] + 1);
    chk($sformatf("u%0d.mem_en", i), 32'(o_en[i]), 32'(en));
    chk($sformatf("u%0d.mem_we", i), 32'(o_we[i]), 32'(en && awe[i]));
    chk($sformatf("u%0d.mem_addr", i), 32'(o_addr[i]), 32'(aaddr[i]));
    chk($sformatf("u%0d.mem_wdata", i), 32'(o_wdata[i]), 32'(awd[i]));
    chk($sformatf("u%0d.dm_rdy", i), 32'(o_dmrdy[i]), 32'(rdy && adm[i]));
    chk($sformatf("u%0d.if_rdy", i), 32'(o_ifrdy[i]), 32'(rdy && !adm[i]));
    chk($sformatf("u%0d.busy", i), 32'(o_busy[i]), 32'(bz));
    chk($sformatf("u%0d.if_data", i), 32'(o_ifdata[i]), 32'(xif[i]));
    chk($sformatf("u%0d.dm_rdata", i), 32'(o_dmdata[i]), 32'(xdm[i]));
  endtask

  task automatic step();
    model_decide(0);
    model_decide(1);
    @(posedge clk);
    #1;
    cyc++;
    model_check(0);
    model_check(1);
  endtask

  task automatic wait_rdy(input bit dm, output int t);
    bit seen;
    seen = 0;
    t = -1;
    for (int n = 0; n < 60 && !seen; n++) begin
      step();
      if (dm ? o_dmrdy[0] : o_ifrdy[0]) begin
        seen = 1;
        t = cyc;
      end
    end
    chk(dm ? "dm_rdy_timeout" : "if_rdy_timeout", 32'(seen), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int td, tf, n, en_cnt0, en_cnt1, rdy_at1, gc;

    // Reset held with a pending fetch: everything reads zero
    if_re = 1'b1;
    if_addr = 16'h0002;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    model_check(0);
    model_check(1);
    rst_n = 1'b1;
    model_reset();
    step();
    chk("reset_release_busy", 32'(o_busy[0]), 32'd1);
    wait_rdy(0, tf);
    if_re = 1'b0;
    idle(8);

    // Lone fetch
    mem_rdata = 16'hB123;
    if_addr   = 16'h0010;
    if_re     = 1'b1;
    wait_rdy(0, tf);
    if_re = 1'b0;
    chk("lone_fetch_data", 32'(o_ifdata[0]), 32'h0000B123);
    idle(8);

    // Write then read
    mem_rdata = 16'hFFFF;
    dm_addr   = 16'h0040;
    dm_wdata  = 16'h5A5A;
    dm_we     = 1'b1;
    wait_rdy(1, td);
    dm_we = 1'b0;
    chk("write_keeps_rdata", 32'(o_dmdata[0]), 32'd0);
    idle(8);
    mem_rdata = 16'h5A5A;
    dm_re     = 1'b1;
    wait_rdy(1, td);
    dm_re = 1'b0;
    chk("read_data", 32'(o_dmdata[0]), 32'h00005A5A);
    idle(8);

    // Contention: data first, fetch MEM_LAT+2 cycles later
    gl.delete();
    mem_rdata = 16'h1111;
    if_addr = 16'h0100;
    dm_addr = 16'h0200;
    if_re = 1'b1;
    dm_re = 1'b1;
    wait_rdy(1, td);
    dm_re = 1'b0;
    wait_rdy(0, tf);
    if_re = 1'b0;
    chk("contention_spacing", 32'(tf - td), 32'd6);
    chk("contention_first", 32'(gl.size() > 0 ? gl[0] : 0), 32'("D"));
    idle(8);

    // Anti-starvation: both held continuously
    gl.delete();
    if_re = 1'b1;
    dm_re = 1'b1;
    n = 0;
    while (gl.size() < 4 && n < 100) begin
      step();
      n++;
    end
    if_re = 1'b0;
    dm_re = 1'b0;
    chk("starve_cnt", 32'(gl.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("starve_order%0d", k), 32'(gl.size() > k ? gl[k] : 0),
          32'((k % 2 == 0) ? "D" : "F"));
    idle(10);

    // Randomized traffic, requesters honour the hold-until-ready protocol of u0
    for (int k = 0; k < 400; k++) begin
      mem_rdata = 16'($urandom);
      if (!if_re && ($urandom_range(0, 2) == 0)) begin
        if_re = 1'b1;
        if_addr = 16'($urandom);
      end
      if (!dm_re && !dm_we && ($urandom_range(0, 2) == 0)) begin
        n = int'($urandom_range(0, 9));
        dm_we = (n < 4) || (n == 9);
        dm_re = (n >= 4);
        dm_addr = 16'($urandom);
        dm_wdata = 16'($urandom);
      end
      step();
      if (o_ifrdy[0]) if_re = 1'b0;
      if (o_dmrdy[0]) begin
        dm_re = 1'b0;
        dm_we = 1'b0;
      end
    end
    if_re = 1'b0;
    dm_re = 1'b0;
    dm_we = 1'b0;
    idle(10);

    // Abort: reset asserted in the 2nd cycle of a fetch access
    if_addr = 16'h1234;
    if_re = 1'b1;
    step();
    step();
    chk("abort_pre_en", 32'(o_en[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    if_re = 1'b0;
    model_reset();
    model_check(0);
    model_check(1);
    repeat (2) @(posedge clk);
    #1;
    model_check(0);
    rst_n = 1'b1;
    model_reset();
    idle(10);

    // MEM_LAT=1 lone fetch alongside MEM_LAT=4 (request pulsed for one cycle)
    mem_rdata = 16'hB123;
    if_addr = 16'h0010;
    if_re = 1'b1;
    gc = cyc;
    step();
    if_re = 1'b0;
    en_cnt0 = 0;
    en_cnt1 = 0;
    rdy_at1 = -1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      en_cnt0 += int'(o_en[0]);
      en_cnt1 += int'(o_en[1]);
      if (o_ifrdy[1] && rdy_at1 < 0) rdy_at1 = cyc;
    end
    chk("lat1_en_cycles", 32'(en_cnt1), 32'd1);
    chk("lat4_en_cycles", 32'(en_cnt0), 32'd4);
    chk("lat1_rdy_time", 32'(rdy_at1 - gc), 32'd2);
    chk("lat1_data", 32'(o_ifdata[1]), 32'h0000B123);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
